// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the ID/EX stage and ALU control unit.
package pipe_pkg;

   localparam int ZERO_REG = 31;

   localparam logic [10:0] LDUR_OP = 11'b11111000010;
   localparam logic [10:0] STUR_OP = 11'b11111000000;

   typedef struct packed {
      logic valid;
      logic alu_on;
      logic mem_read;
      logic mem_write;
      logic reg_write;
   } ex_ctrl_t;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      BUBBLE = 1'b1
   } id_ex_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side registered outputs of the ID/EX pipeline register.
interface id_ex_if #(
   parameter int OPC_W  = 11,
   parameter int DATA_W = 64,
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic [OPC_W-1:0]  id_opcode;
   logic              id_alu_on;
   logic              id_uses_rn;
   logic              id_uses_rm;
   logic [REG_AW-1:0] id_rn;
   logic [REG_AW-1:0] id_rm;
   logic [REG_AW-1:0] id_rd;
   logic [DATA_W-1:0] id_rdata1;
   logic [DATA_W-1:0] id_rdata2;
   logic [DATA_W-1:0] id_imm;
   logic              id_mem_read;
   logic              id_mem_write;
   logic              id_reg_write;
   logic              flush;
   logic              ext_stall;

   logic              hold_if_id;
   logic              ex_valid;
   logic [OPC_W-1:0]  ex_opcode;
   logic              ex_alu_on;
   logic [REG_AW-1:0] ex_rn;
   logic [REG_AW-1:0] ex_rm;
   logic [REG_AW-1:0] ex_rd;
   logic [DATA_W-1:0] ex_rdata1;
   logic [DATA_W-1:0] ex_rdata2;
   logic [DATA_W-1:0] ex_imm;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_reg_write;

   modport master (
      output id_valid, id_opcode, id_alu_on, id_uses_rn, id_uses_rm,
             id_rn, id_rm, id_rd, id_rdata1, id_rdata2, id_imm,
             id_mem_read, id_mem_write, id_reg_write, flush, ext_stall,
      input  hold_if_id, ex_valid, ex_opcode, ex_alu_on, ex_rn, ex_rm, ex_rd,
             ex_rdata1, ex_rdata2, ex_imm, ex_mem_read, ex_mem_write, ex_reg_write
   );

   modport slave (
      input  id_valid, id_opcode, id_alu_on, id_uses_rn, id_uses_rm,
             id_rn, id_rm, id_rd, id_rdata1, id_rdata2, id_imm,
             id_mem_read, id_mem_write, id_reg_write, flush, ext_stall,
      output hold_if_id, ex_valid, ex_opcode, ex_alu_on, ex_rn, ex_rm, ex_rd,
             ex_rdata1, ex_rdata2, ex_imm, ex_mem_read, ex_mem_write, ex_reg_write
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the ID instruction.
module load_use_detect
   import pipe_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = pipe_pkg::ZERO_REG
)(
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              id_valid,
   input  logic              id_uses_rn,
   input  logic              id_uses_rm,
   input  logic [REG_AW-1:0] id_rn,
   input  logic [REG_AW-1:0] id_rm,
   output logic              hazard
);

   logic rn_match;
   logic rm_match;
   logic load_in_ex;

   // XZR always reads as zero, so a load targeting it never produces a dependency
   assign load_in_ex = ex_valid & ex_mem_read & (ex_rd != REG_AW'(ZERO_REG));
   assign rn_match   = id_uses_rn & (id_rn == ex_rd);
   assign rm_match   = id_uses_rm & (id_rm == ex_rd);
   assign hazard     = load_in_ex & id_valid & (rn_match | rm_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and global stall.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int OPC_W    = 11,
   parameter int DATA_W   = 64,
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = pipe_pkg::ZERO_REG
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   parameter int CNT_W    = 32
`endif
)(
   input  logic        clk,
   input  logic        reset,
   id_ex_if.slave      pipe
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [CNT_W-1:0] bubble_count
`endif
);

   ex_ctrl_t          ctrl_q,   ctrl_d;
   logic [OPC_W-1:0]  opcode_q, opcode_d;
   logic [REG_AW-1:0] rn_q,     rn_d;
   logic [REG_AW-1:0] rm_q,     rm_d;
   logic [REG_AW-1:0] rd_q,     rd_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [DATA_W-1:0] rdata2_q, rdata2_d;
   logic [DATA_W-1:0] imm_q,    imm_d;
   id_ex_state_e      state_q,  state_d;

   logic hazard;
   logic hold_if_id;
   logic load_bubble;
   logic capture;

   load_use_detect #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
   ) u_detect (
      .ex_valid    (ctrl_q.valid),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rd       (rd_q),
      .id_valid    (pipe.id_valid),
      .id_uses_rn  (pipe.id_uses_rn),
      .id_uses_rm  (pipe.id_uses_rm),
      .id_rn       (pipe.id_rn),
      .id_rm       (pipe.id_rm),
      .hazard      (hazard)
   );

   // Under a global stall IF/ID is already frozen; the hazard is re-evaluated once it lifts
   assign hold_if_id  = hazard & ~pipe.flush & ~pipe.ext_stall & (state_q == RUN);
   assign load_bubble = pipe.flush | hold_if_id;
   assign capture     = ~pipe.flush & ~pipe.ext_stall & ~hold_if_id;

   always_comb begin
      ctrl_d   = ctrl_q;
      opcode_d = opcode_q;
      rn_d     = rn_q;
      rm_d     = rm_q;
      rd_d     = rd_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      imm_d    = imm_q;
      if (load_bubble) begin
         ctrl_d   = '0;
         opcode_d = '0;
         rn_d     = '0;
         rm_d     = '0;
         rd_d     = '0;
         rdata1_d = '0;
         rdata2_d = '0;
         imm_d    = '0;
      end else if (capture) begin
         ctrl_d   = pipe.id_valid ? ex_ctrl_t'{valid:     1'b1,
                                               alu_on:    pipe.id_alu_on,
                                               mem_read:  pipe.id_mem_read,
                                               mem_write: pipe.id_mem_write,
                                               reg_write: pipe.id_reg_write}
                                  : ex_ctrl_t'('0);
         opcode_d = pipe.id_opcode;
         rn_d     = pipe.id_rn;
         rm_d     = pipe.id_rm;
         rd_d     = pipe.id_rd;
         rdata1_d = pipe.id_rdata1;
         rdata2_d = pipe.id_rdata2;
         imm_d    = pipe.id_imm;
      end
   end

   // BUBBLE masks the hazard for one free edge so each load costs at most one bubble
   always_comb begin
      state_d = state_q;
      if (pipe.flush) begin
         state_d = RUN;
      end else if (!pipe.ext_stall) begin
         state_d = hold_if_id ? BUBBLE : RUN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q   <= '0;
         opcode_q <= '0;
         rn_q     <= '0;
         rm_q     <= '0;
         rd_q     <= '0;
         rdata1_q <= '0;
         rdata2_q <= '0;
         imm_q    <= '0;
         state_q  <= RUN;
      end else begin
         ctrl_q   <= ctrl_d;
         opcode_q <= opcode_d;
         rn_q     <= rn_d;
         rm_q     <= rm_d;
         rd_q     <= rd_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
         imm_q    <= imm_d;
         state_q  <= state_d;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Only hazard bubbles are counted; flush bubbles never raise hold_if_id
   assign bubble_cnt_d = hold_if_id ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_count = bubble_cnt_q;
`endif

   assign pipe.hold_if_id   = hold_if_id;
   assign pipe.ex_valid     = ctrl_q.valid;
   assign pipe.ex_alu_on    = ctrl_q.alu_on;
   assign pipe.ex_mem_read  = ctrl_q.mem_read;
   assign pipe.ex_mem_write = ctrl_q.mem_write;
   assign pipe.ex_reg_write = ctrl_q.reg_write;
   assign pipe.ex_opcode    = opcode_q;
   assign pipe.ex_rn        = rn_q;
   assign pipe.ex_rm        = rm_q;
   assign pipe.ex_rd        = rd_q;
   assign pipe.ex_rdata1    = rdata1_q;
   assign pipe.ex_rdata2    = rdata2_q;
   assign pipe.ex_imm       = imm_q;

endmodule
